// File: rtl/carfield_cfg_pkg.sv
// Shared Carfield configuration: domain count and indices, divider defaults
// and the per-domain sequencer state encoding.
package carfield_cfg_pkg;

  localparam int unsigned CarfieldNumDomains = 6;
  localparam int unsigned CarfieldDivWidth   = 8;

  typedef struct packed {
    int unsigned l2;
    int unsigned spatz;
    int unsigned pulp;
    int unsigned secured;
    int unsigned safed;
    int unsigned periph;
  } carfield_domain_idx_t;

  localparam carfield_domain_idx_t CarfieldDomainIdx = '{
    l2:      0,
    spatz:   1,
    pulp:    2,
    secured: 3,
    safed:   4,
    periph:  5
  };

  localparam int unsigned NumDomains = CarfieldNumDomains;

  // Boot-time divider value per domain, entry d belongs to domain index d.
  localparam logic [CarfieldNumDomains-1:0][CarfieldDivWidth-1:0] CarfieldDivDefault = {
    8'd4,  // periph
    8'd1,  // safed
    8'd1,  // secured
    8'd2,  // pulp
    8'd4,  // spatz
    8'd2   // l2
  };

  typedef enum logic [2:0] {
    IDLE,
    DIV_CFG,
    CLK_ON,
    RST_REL,
    ISO_OFF,
    ISO_ON,
    RST_ON,
    CLK_OFF
  } domain_seq_state_e;

endpackage

// File: rtl/carfield_domain_seq_picker.sv
// Round-robin first-one search: lowest pending index at or after ptr_i,
// wrapping modulo NumDomains.
module carfield_domain_seq_picker #(
  parameter int unsigned NumDomains = 6,
  parameter int unsigned IdxWidth   = 3
) (
  input  logic [NumDomains-1:0] pend_i,
  input  logic [IdxWidth-1:0]   ptr_i,
  output logic [IdxWidth-1:0]   idx_o,
  output logic                  valid_o
);

  // Scanned from the farthest offset down so the nearest pending one wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = int'(NumDomains) - 1; k >= 0; k--) begin
      if (pend_i[IdxWidth'((int'(ptr_i) + k) % int'(NumDomains))]) begin
        idx_o   = IdxWidth'((int'(ptr_i) + k) % int'(NumDomains));
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/carfield_domain_seq.sv
// Per-domain power sequencer: one domain at a time, round-robin. Define
// CARFIELD_DOMAIN_SEQ_TIMEOUT_EN to enable the divider handshake timeout.
module carfield_domain_seq #(
  parameter int unsigned NumDomains      = carfield_cfg_pkg::NumDomains,
  parameter int unsigned DivWidth        = carfield_cfg_pkg::CarfieldDivWidth,
  parameter int unsigned ClkSettleCycles = 8,
  parameter int unsigned RstHoldCycles   = 16,
  parameter int unsigned IsoCycles       = 4,
  parameter int unsigned TimeoutCycles   = 1024,
  localparam int unsigned IdxW           = $clog2(NumDomains)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumDomains-1:0]          en_req_i,
  input  logic [NumDomains*DivWidth-1:0] div_value_i,
  output logic                           div_valid_o,
  input  logic                           div_ready_i,
  output logic [IdxW-1:0]                div_domain_o,
  output logic [DivWidth-1:0]            div_value_o,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic [NumDomains-1:0]          domain_rst_no,
  output logic [NumDomains-1:0]          iso_o,
  output logic [NumDomains-1:0]          domain_on_o,
  output logic                           busy_o,
  output logic [NumDomains-1:0]          err_o,
  output carfield_cfg_pkg::domain_seq_state_e state_o
);

  import carfield_cfg_pkg::*;

  // Divider handshake: div_valid_o rises on DIV_CFG entry with domain/value
  // latched, both held stable until the edge where div_valid_o & div_ready_i.

  localparam int unsigned MaxA   = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
  localparam int unsigned MaxB   = (IsoCycles > TimeoutCycles) ? IsoCycles : TimeoutCycles;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ClkSettleLast = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstHoldLast   = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] IsoLast       = CntW'(IsoCycles - 1);
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast   = CntW'(TimeoutCycles - 1);
`endif

  domain_seq_state_e         state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           cur_q, cur_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic                      div_valid_q, div_valid_d;
  logic [IdxW-1:0]           div_domain_q, div_domain_d;
  logic [DivWidth-1:0]       div_value_q, div_value_d;
  logic [NumDomains-1:0]     clk_en_q, clk_en_d;
  logic [NumDomains-1:0]     rst_n_q, rst_n_d;
  logic [NumDomains-1:0]     iso_q, iso_d;
  logic [NumDomains-1:0]     on_q, on_d;
  logic                      busy_q, busy_d;
  logic [NumDomains-1:0]     err_q, err_d;

  logic [NumDomains-1:0]     pend;
  logic [IdxW-1:0]           sel_idx;
  logic                      sel_valid;
  logic [NumDomains-1:0][DivWidth-1:0] div_vals;

  assign div_vals = div_value_i;
  // A domain in error is parked until its request is withdrawn.
  assign pend     = (en_req_i ^ on_q) & ~err_q;

  carfield_domain_seq_picker #(
    .NumDomains (NumDomains),
    .IdxWidth   (IdxW)
  ) u_picker (
    .pend_i  (pend),
    .ptr_i   (ptr_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CntW'(1);
    cur_d        = cur_q;
    ptr_d        = ptr_q;
    div_valid_d  = div_valid_q;
    div_domain_d = div_domain_q;
    div_value_d  = div_value_q;
    clk_en_d     = clk_en_q;
    rst_n_d      = rst_n_q;
    iso_d        = iso_q;
    on_d         = on_q;
    busy_d       = busy_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_valid) begin
          cur_d  = sel_idx;
          busy_d = 1'b1;
          ptr_d  = (sel_idx == IdxW'(NumDomains - 1)) ? '0 : sel_idx + IdxW'(1);
          if (en_req_i[sel_idx]) begin
            state_d      = DIV_CFG;
            div_valid_d  = 1'b1;
            div_domain_d = sel_idx;
            div_value_d  = div_vals[sel_idx];
          end else begin
            state_d        = ISO_ON;
            iso_d[sel_idx] = 1'b1;
            on_d[sel_idx]  = 1'b0;
          end
        end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
        err_d = err_q & en_req_i;
`endif
      end
      DIV_CFG: begin
        if (div_valid_q && div_ready_i) begin
          div_valid_d     = 1'b0;
          clk_en_d[cur_q] = 1'b1;
          state_d         = CLK_ON;
          cnt_d           = '0;
        end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          div_valid_d  = 1'b0;
          err_d[cur_q] = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
          cnt_d        = '0;
        end
`endif
      end
      CLK_ON: begin
        if (cnt_q == ClkSettleLast) begin
          rst_n_d[cur_q] = 1'b1;
          state_d        = RST_REL;
          cnt_d          = '0;
        end
      end
      RST_REL: begin
        if (cnt_q == IsoLast) begin
          iso_d[cur_q] = 1'b0;
          state_d      = ISO_OFF;
          cnt_d        = '0;
        end
      end
      ISO_OFF: begin
        if (cnt_q == IsoLast) begin
          on_d[cur_q] = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
          cnt_d       = '0;
        end
      end
      ISO_ON: begin
        if (cnt_q == IsoLast) begin
          rst_n_d[cur_q] = 1'b0;
          state_d        = RST_ON;
          cnt_d          = '0;
        end
      end
      RST_ON: begin
        if (cnt_q == RstHoldLast) begin
          clk_en_d[cur_q] = 1'b0;
          state_d         = CLK_OFF;
          cnt_d           = '0;
        end
      end
      CLK_OFF: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifndef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    err_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      ptr_q        <= '0;
      div_valid_q  <= 1'b0;
      div_domain_q <= '0;
      div_value_q  <= '0;
      clk_en_q     <= '0;
      rst_n_q      <= '0;
      iso_q        <= '1;
      on_q         <= '0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      ptr_q        <= ptr_d;
      div_valid_q  <= div_valid_d;
      div_domain_q <= div_domain_d;
      div_value_q  <= div_value_d;
      clk_en_q     <= clk_en_d;
      rst_n_q      <= rst_n_d;
      iso_q        <= iso_d;
      on_q         <= on_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign div_valid_o   = div_valid_q;
  assign div_domain_o  = div_domain_q;
  assign div_value_o   = div_value_q;
  assign clk_en_o      = clk_en_q;
  assign domain_rst_no = rst_n_q;
  assign iso_o         = iso_q;
  assign domain_on_o   = on_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Bench for carfield_domain_seq: a schedule-based reference model plus
// directed scenarios from reset, single domain, round-robin, mid-sequence reset.
`timescale 1ns/1ps
module tb_carfield_domain_seq;
  import carfield_cfg_pkg::*;

  localparam int N      = 6;
  localparam int DW     = 8;
  localparam int IW     = 3;
  localparam int SETTLE = 8;
  localparam int HOLD   = 16;
  localparam int ISO    = 4;
  localparam int TMO    = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        en_req = '0;
  logic [N-1:0][DW-1:0] div_arr = CarfieldDivDefault;
  logic                div_ready = 1'b1;
  logic                div_valid;
  logic [IW-1:0]       div_domain;
  logic [DW-1:0]       div_value;
  logic [N-1:0]        clk_en, rst_n, iso, on, err;
  logic                busy;
  domain_seq_state_e   dbg_state;

  always #5 clk = ~clk;

  carfield_domain_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_req_i      (en_req),
    .div_value_i   (div_arr),
    .div_valid_o   (div_valid),
    .div_ready_i   (div_ready),
    .div_domain_o  (div_domain),
    .div_value_o   (div_value),
    .clk_en_o      (clk_en),
    .domain_rst_no (rst_n),
    .iso_o         (iso),
    .domain_on_o   (on),
    .busy_o        (busy),
    .err_o         (err),
    .state_o       (dbg_state)
  );

  int checks = 0;
  int passes = 0;

  // ---------------- reference model ----------------
  // Each sequence is a timeline: at selection (and at the divider handshake)
  // the output changes are scheduled at fixed offsets from that edge.
  localparam int EvRstRel = 0, EvIsoOff = 1, EvUpDone = 2, EvRstOn = 3, EvClkOff = 4, EvDownDone = 5;
  typedef struct { int at; int kind; } ev_t;
  ev_t ev_q[$];

  logic [N-1:0]  m_clk, m_rstn, m_iso, m_on, m_err;
  logic          m_busy, m_dv;
  logic [IW-1:0] m_dd, m_cur, m_ptr, ix;
  logic [DW-1:0] m_dval;
  bit            m_active, m_wait_div;
  int            m_start, cyc;

  always @(posedge clk) begin
    logic [N-1:0] pend;
    ev_t e;
    if (rst) begin
      m_clk = '0; m_rstn = '0; m_iso = '1; m_on = '0; m_err = '0;
      m_busy = 0; m_dv = 0; m_dd = '0; m_dval = '0; m_ptr = '0; m_cur = '0;
      m_active = 0; m_wait_div = 0; ev_q.delete();
    end else begin
      cyc++;
      if (!m_active) begin
        pend = (en_req ^ m_on) & ~m_err;
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
        m_err = m_err & en_req;
`endif
        for (int k = 0; k < N; k++) begin
          ix = IW'((int'(m_ptr) + k) % N);
          if (pend[ix]) begin m_cur = ix; m_active = 1; break; end
        end
        if (m_active) begin
          m_busy  = 1;
          m_ptr   = IW'((int'(m_cur) + 1) % N);
          m_start = cyc;
          if (en_req[m_cur]) begin
            m_dv = 1; m_dd = m_cur; m_dval = div_arr[m_cur]; m_wait_div = 1;
          end else begin
            m_iso[m_cur] = 1; m_on[m_cur] = 0;
            ev_q.push_back('{cyc + ISO, EvRstOn});
            ev_q.push_back('{cyc + ISO + HOLD, EvClkOff});
            ev_q.push_back('{cyc + ISO + HOLD + 1, EvDownDone});
          end
        end
      end else if (m_wait_div) begin
        if (div_ready) begin
          m_dv = 0; m_wait_div = 0; m_clk[m_cur] = 1;
          ev_q.push_back('{cyc + SETTLE, EvRstRel});
          ev_q.push_back('{cyc + SETTLE + ISO, EvIsoOff});
          ev_q.push_back('{cyc + SETTLE + 2 * ISO, EvUpDone});
        end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
        else if (cyc - m_start == TMO) begin
          m_dv = 0; m_wait_div = 0; m_err[m_cur] = 1; m_busy = 0; m_active = 0;
        end
`endif
      end else begin
        while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
          e = ev_q.pop_front();
          case (e.kind)
            EvRstRel:   m_rstn[m_cur] = 1;
            EvIsoOff:   m_iso[m_cur]  = 0;
            EvUpDone:   begin m_on[m_cur] = 1; m_busy = 0; m_active = 0; end
            EvRstOn:    m_rstn[m_cur] = 0;
            EvClkOff:   m_clk[m_cur]  = 0;
            default:    begin m_busy = 0; m_active = 0; end
          endcase
        end
      end
    end
  end

  wire [5*N+1:0]     dut_vec = {clk_en, rst_n, iso, on, err, busy, div_valid};
  wire [5*N+1:0]     mdl_vec = {m_clk, m_rstn, m_iso, m_on, m_err, m_busy, m_dv};
  wire [IW+DW-1:0]   dut_div = div_valid ? {div_domain, div_value} : '0;
  wire [IW+DW-1:0]   mdl_div = m_dv ? {m_dd, m_dval} : '0;
  localparam logic [5*N+1:0] RST_VEC = {6'h00, 6'h00, 6'h3f, 6'h00, 6'h00, 1'b0, 1'b0};

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; en_req = '0; div_ready = 1; div_arr = CarfieldDivDefault;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== RST_VEC || div_domain !== '0 || div_value !== '0 || dbg_state !== IDLE)
        $display("FAIL reset cyc=%0d got=%h dom=%0d val=%0d st=%0d exp=%h", i, dut_vec, div_domain, div_value, dbg_state, RST_VEC);
      else passes++;
    end
  endtask

  task automatic test_single_up_down();
    int d, t, pulse, t_clk, t_rst, t_iso, t_on, t_busy, t_isoon, t_rstoff, t_clkoff;
    logic [IW-1:0] seen_dom;
    logic [DW-1:0] seen_val;
    d = int'(CarfieldDomainIdx.pulp);
    pulse = 0; t_clk = -1; t_rst = -1; t_iso = -1; t_on = -1;
    seen_dom = '0; seen_val = '0;
    div_arr[d] = 8'd3; div_ready = 1; en_req[d] = 1'b1;
    for (t = 0; t < 40 && t_on < 0; t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL up_model t=%0d got=%h/%h exp=%h/%h", t, dut_vec, dut_div, mdl_vec, mdl_div);
      else passes++;
      if (div_valid) begin pulse++; seen_dom = div_domain; seen_val = div_value; end
      if (clk_en[d] && t_clk < 0) t_clk = t;
      if (rst_n[d] && t_rst < 0) t_rst = t;
      if (!iso[d] && t_iso < 0) t_iso = t;
      if (on[d] && t_on < 0) t_on = t;
    end
    checks++;
    if (pulse !== 1 || seen_dom !== IW'(d) || seen_val !== 8'd3)
      $display("FAIL up_div pulse=%0d dom=%0d val=%0d exp 1/%0d/3", pulse, seen_dom, seen_val, d);
    else passes++;
    checks++;
    if (t_on < 0 || t_rst - t_clk !== SETTLE || t_iso - t_rst !== ISO || t_on - t_iso !== ISO)
      $display("FAIL up_timing clk=%0d rst=%0d iso=%0d on=%0d exp gaps 8/4/4", t_clk, t_rst, t_iso, t_on);
    else passes++;

    t_busy = -1; t_isoon = -1; t_rstoff = -1; t_clkoff = -1;
    en_req[d] = 1'b0;
    for (t = 0; t < 40 && !(t_clkoff >= 0 && !busy); t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL down_model t=%0d got=%h exp=%h", t, dut_vec, mdl_vec);
      else passes++;
      if (busy && t_busy < 0) t_busy = t;
      if (iso[d] && !on[d] && t_isoon < 0) t_isoon = t;
      if (!rst_n[d] && t_rstoff < 0) t_rstoff = t;
      if (!clk_en[d] && t_clkoff < 0) t_clkoff = t;
    end
    checks++;
    if (t_clkoff < 0 || t_isoon !== t_busy || t_rstoff - t_isoon !== ISO || t_clkoff - t_rstoff !== HOLD)
      $display("FAIL down_timing busy=%0d iso=%0d rst=%0d clk=%0d exp gaps 0/4/16", t_busy, t_isoon, t_rstoff, t_clkoff);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [IW-1:0] exp_q[$];
    logic prev_busy;
    bit added;
    int t;
    do_reset();
    exp_q = '{3'd0, 3'd2, 3'd5};
    added = 0; prev_busy = 0;
    en_req = 6'b100101;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL rr_model t=%0d got=%h/%h exp=%h/%h", t, dut_vec, dut_div, mdl_vec, mdl_div);
      else passes++;
      if (busy && !prev_busy && div_valid) begin
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL rr_order got=%0d exp=none", div_domain);
        else if (div_domain !== exp_q[0])
          $display("FAIL rr_order got=%0d exp=%0d", div_domain, exp_q.pop_front());
        else begin passes++; void'(exp_q.pop_front()); end
      end
      prev_busy = busy;
      if (!added && on == 6'b100101 && !busy) begin
        en_req[1] = 1'b1; exp_q.push_back(3'd1); added = 1;
      end
      if (added && on == 6'b100111 && !busy) break;
    end
    checks++;
    if (exp_q.size() != 0 || !added || on !== 6'b100111)
      $display("FAIL rr_done left=%0d on=%b exp 0/100111", exp_q.size(), on);
    else passes++;
  endtask

  task automatic test_reset_mid_sequence();
    int t;
    bit found;
    do_reset();
    en_req[4] = 1'b1;
    found = 0;
    for (t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) $display("FAIL mid_model t=%0d got=%h exp=%h", t, dut_vec, mdl_vec);
      else passes++;
      found = clk_en[4];
    end
    checks++;
    if (!found) $display("FAIL mid_clk_on got=0 exp=1");
    else passes++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (dut_vec !== RST_VEC || dbg_state !== IDLE)
      $display("FAIL mid_reset got=%h st=%0d exp=%h", dut_vec, dbg_state, RST_VEC);
    else passes++;
    rst = 0;
    @(negedge clk);
    checks++;
    if (!div_valid || div_domain !== 3'd4 || !busy || clk_en !== '0)
      $display("FAIL mid_reseq valid=%b dom=%0d busy=%b clk=%b exp 1/4/1/0", div_valid, div_domain, busy, clk_en);
    else passes++;
    for (t = 0; t < 30 && !(on[4] && !busy); t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL mid_after t=%0d got=%h exp=%h", t, dut_vec, mdl_vec);
      else passes++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL rand_model t=%0d got=%h/%h exp=%h/%h", t, dut_vec, dut_div, mdl_vec, mdl_div);
      else passes++;
      div_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) en_req = N'($urandom);
      if ($urandom_range(0, 49) == 0) div_arr[$urandom_range(0, N - 1)] = DW'($urandom);
    end
  endtask

  task automatic test_div_stall();
    int t;
    do_reset();
    div_ready = 0;
    en_req[3] = 1'b1;
    for (t = 0; t < TMO + 20; t++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || dut_div !== mdl_div)
        $display("FAIL stall_model t=%0d got=%h exp=%h", t, dut_vec, mdl_vec);
      else passes++;
    end
`ifdef CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
    checks++;
    if (err !== 6'b001000 || div_valid || clk_en[3] || busy)
      $display("FAIL timeout err=%b valid=%b clk=%b busy=%b exp 001000/0/0/0", err, div_valid, clk_en, busy);
    else passes++;
    en_req[3] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (err !== '0 || busy) $display("FAIL err_clear err=%b busy=%b exp 0/0", err, busy);
    else passes++;
`else
    checks++;
    if (!div_valid || div_domain !== 3'd3 || err !== '0 || clk_en[3])
      $display("FAIL stall valid=%b dom=%0d err=%b clk=%b exp 1/3/0/0", div_valid, div_domain, err, clk_en);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_up_down();
    test_round_robin();
    test_reset_mid_sequence();
    test_random();
    test_div_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/carfield_domain_seq.md
Name: carfield_domain_seq

Overview:
Per-domain power-up/power-down sequencer for Carfield islands: l2, spatz, pulp, secured, safed and periph.
- Compares each domain's requested state with its current state and serves one domain at a time, round-robin.
- Power-up order: program clock divider, enable clock, release reset, drop isolation.
- Power-down order is the reverse.
- Sits between the SoC control registers and the per-domain clock dividers, clock gates and reset/isolation cells.

Parameters:
NumDomains, 6, number of sequenced domains (matches CarfieldNumDomains)
DivWidth, 8, clock divider value width
ClkSettleCycles, 8, cycles waited after clock enable before reset release
RstHoldCycles, 16, cycles reset is held asserted on power-down before the clock is gated
IsoCycles, 4, cycles waited after an isolation change
TimeoutCycles, 1024, divider handshake timeout (used only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
en_req_i  in  NumDomains  requested domain state (1=on), level
div_value_i  in  NumDomains*DivWidth  divider value per domain, domain d at [d*DivWidth +: DivWidth]
div_valid_o  out  1  divider programming request
div_ready_i  in  1  divider programming accepted
div_domain_o  out  $clog2(NumDomains)  domain index being programmed
div_value_o  out  DivWidth  divider value being programmed
clk_en_o  out  NumDomains  per-domain clock gate enable
domain_rst_no  out  NumDomains  per-domain reset, active-low
iso_o  out  NumDomains  per-domain isolation, 1=isolated
domain_on_o  out  NumDomains  domain fully up
busy_o  out  1  sequence in progress
err_o  out  NumDomains  sticky divider-timeout error (optional feature)

Behaviour:
- Reset values:
  - clk_en_o=0, domain_rst_no=0, iso_o='1, domain_on_o=0.
  - div_valid_o=0, div_domain_o=0, div_value_o=0.
  - busy_o=0, err_o=0, round-robin pointer=0.
  - FSM in IDLE, counter=0.
  - A reset asserted mid-sequence returns every output to these values on the next edge; there is no partial completion.
- Pending vector: pend = en_req_i ^ domain_on_o, masked by ~err_o.
- IDLE:
  - If pend!=0, select the first pending index at or after ptr, wrapping modulo NumDomains.
  - Latch the index into cur, set busy_o=1.
  - Latch the direction: up if en_req_i[cur]=1.
  - Go to DIV_CFG (up) or ISO_ON (down).
  - ptr=cur+1 mod NumDomains.
  - Selection takes 1 cycle; busy_o rises the cycle after pend becomes nonzero.
- Up path:
  - DIV_CFG:
    - div_valid_o=1, div_domain_o=cur, div_value_o=div_value_i[cur], latched on entry and held stable while valid.
    - On valid&ready: drop valid, go to CLK_ON.
  - CLK_ON: clk_en_o[cur]=1, count ClkSettleCycles, go to RST_REL.
  - RST_REL: domain_rst_no[cur]=1, count IsoCycles, go to ISO_OFF.
  - ISO_OFF: iso_o[cur]=0, count IsoCycles, then domain_on_o[cur]=1, go to IDLE.
- Down path:
  - ISO_ON: iso_o[cur]=1 and domain_on_o[cur]=0 on entry, count IsoCycles, go to RST_ON.
  - RST_ON: domain_rst_no[cur]=0, count RstHoldCycles, go to CLK_OFF.
  - CLK_OFF: clk_en_o[cur]=0, go to IDLE.
- Counter: each wait lasts exactly N cycles in state; the counter is cleared on state entry.
- en_req_i changes during a sequence are ignored. The sequence always completes; pend is re-evaluated in IDLE, so a toggled request triggers the reverse sequence next.
- In IDLE, busy_o=0 for at least 1 cycle between sequences.
- Simultaneous requests are served one per sequence in round-robin order. Domains not being sequenced hold their outputs.

Optional Feature:
CARFIELD_DOMAIN_SEQ_TIMEOUT_EN
- Defined:
  - DIV_CFG counts cycles.
  - If div_ready_i has not arrived after TimeoutCycles, drop div_valid_o, set err_o[cur], go to IDLE. The domain stays off.
  - err_o[d] clears when en_req_i[d]=0 is sampled in IDLE.
- Undefined:
  - DIV_CFG waits indefinitely; err_o tied to 0.

Decomposition:
- Shared package carfield_cfg_pkg holds:
  - domain_seq_state_e enum (IDLE, DIV_CFG, CLK_ON, RST_REL, ISO_OFF, ISO_ON, RST_ON, CLK_OFF).
  - Default divider-value constant per domain.
  - NumDomains, taken from CarfieldNumDomains.
  - Domain indices, taken from CarfieldDomainIdx.
- Sub-module carfield_domain_seq_picker: combinational round-robin first-one search over pend starting at ptr; outputs index and valid.

Test Plan:
1. Reset release, en_req_i=0 → all outputs at reset values, busy_o=0 for 50 cycles.
2. en_req_i[2]=1, div_value_i[2]=3, div_ready_i=1 → div_valid_o for 1 cycle with div_domain_o=2, div_value_o=3.
   - Then clk_en_o[2]=1.
   - domain_rst_no[2]=1 8 cycles later.
   - iso_o[2]=0 4 cycles after that.
   - domain_on_o[2]=1 4 cycles later.
3. Domain 2 on, en_req_i[2]=0 → iso_o[2]=1 and domain_on_o[2]=0 immediately.
   - domain_rst_no[2]=0 after 4 cycles.
   - clk_en_o[2]=0 after 16 more cycles.
4. en_req_i=6'b100101 asserted in one cycle → domains served in order 0,2,5.
   - Then request domain 1 while ptr=0 → served next.
5. Reset asserted during CLK_ON of domain 4 → next edge clk_en_o=0, iso_o='1, busy_o=0.
   - After release the domain re-sequences from DIV_CFG.
6. With CARFIELD_DOMAIN_SEQ_TIMEOUT_EN, div_ready_i=0 → after 1024 cycles div_valid_o=0, err_o[cur]=1, clk_en_o[cur]=0.
   - Deasserting the request clears err_o[cur].
